frame_port_arbiter: RTL and testbench

Single-port arbiter and sequencer for the grayscale frame buffer BRAM. It shares one BRAM port between three requesters: the pixel loader (UART → rgb2gray writes), the VGA scanout reader and the Sobel engine (reads plus write-back). It converts (row, column) coordinates to linear addresses and enforces the load → process ordering through `all_loaded`. It sits between the parse/rgb2gray path, the Sobel and VGA blocks, and the BRAM macro.

---
 rtl/frame_port_arbiter_if.sv | 42 ++++
 rtl/frame_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_frame_port_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_port_arbiter_if.sv
// Bundle of requester handshakes and BRAM port signals shared by the frame buffer arbiter.
// The slave modport is the arbiter side; master is the requester/BRAM side.
interface frame_port_arbiter_if #(
    parameter int unsigned ADDR_W = 19
) ();
    logic              ld_req;
    logic [7:0]        ld_wdata;
    logic              ld_gnt;
    logic              vga_req;
    logic [15:0]       vga_h;
    logic [15:0]       vga_w;
    logic              vga_gnt;
    logic              vga_rvalid;
    logic              sob_req;
    logic              sob_we;
    logic [15:0]       sob_h;
    logic [15:0]       sob_w;
    logic [7:0]        sob_wdata;
    logic              sob_gnt;
    logic              sob_rvalid;
    logic [7:0]        rdata;
    logic [ADDR_W-1:0] bram_addr;
    logic              bram_we;
    logic [7:0]        bram_wdata;
    logic [7:0]        bram_rdata;
    logic              all_loaded;
    logic              oob_err;

    modport slave (
        input  ld_req, ld_wdata, vga_req, vga_h, vga_w, sob_req, sob_we, sob_h, sob_w,
               sob_wdata, bram_rdata,
        output ld_gnt, vga_gnt, vga_rvalid, sob_gnt, sob_rvalid, rdata, bram_addr, bram_we,
               bram_wdata, all_loaded, oob_err
    );

    modport master (
        output ld_req, ld_wdata, vga_req, vga_h, vga_w, sob_req, sob_we, sob_h, sob_w,
               sob_wdata, bram_rdata,
        input  ld_gnt, vga_gnt, vga_rvalid, sob_gnt, sob_rvalid, rdata, bram_addr, bram_we,
               bram_wdata, all_loaded, oob_err
    );
endinterface

// File: rtl/frame_port_arbiter.sv
// Single-port frame buffer arbiter: VGA > loader > Sobel (Sobel promoted when starved),
// linear address generation, load-complete tracking and a tagged read return path.
module frame_port_arbiter #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_MAX = 8
) (
    input logic                 clk,
    input logic                 reset,
    frame_port_arbiter_if.slave bus
);
    localparam int unsigned NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned SW   = $clog2(STARVE_MAX + 1);
    localparam int unsigned TD   = RD_LAT + 1;

    typedef enum logic [1:0] {GntNone, GntVga, GntLd, GntSob} gnt_e;

    function automatic logic [ADDR_W-1:0] lin_addr(input logic [15:0] h, input logic [15:0] w);
        return ADDR_W'(32'(h) * IMG_WIDTH + 32'(w));
    endfunction

    function automatic logic coord_oob(input logic [15:0] h, input logic [15:0] w);
        return (32'(h) >= IMG_HEIGHT) || (32'(w) >= IMG_WIDTH);
    endfunction

    gnt_e              sel;
    logic              sob_elig, ld_elig, vga_oob, sob_oob;
    logic              rd_issue, rd_sob, rd_oob;
    logic [ADDR_W-1:0] ld_addr_q, ld_addr_d, bram_addr_q, bram_addr_d;
    logic              bram_we_q, bram_we_d;
    logic [7:0]        bram_wdata_q, bram_wdata_d;
    logic              all_loaded_q, all_loaded_d, oob_q, oob_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [TD-1:0]     tag_vld_q, tag_sob_q, tag_oob_q;

    always_comb begin
        sob_elig = all_loaded_q && bus.sob_req;
        ld_elig  = !all_loaded_q && bus.ld_req;
        vga_oob  = coord_oob(bus.vga_h, bus.vga_w);
        sob_oob  = coord_oob(bus.sob_h, bus.sob_w);
        sel      = GntNone;
        if (reset) begin
            sel = GntNone;
        end else if (bus.vga_req) begin
            sel = GntVga;
        end else if (sob_elig && starve_q == SW'(STARVE_MAX)) begin
            sel = GntSob;
        end else if (ld_elig) begin
            sel = GntLd;
        end else if (sob_elig) begin
            sel = GntSob;
        end
    end

    always_comb begin
        ld_addr_d    = ld_addr_q;
        all_loaded_d = all_loaded_q;
        oob_d        = oob_q;
        bram_addr_d  = bram_addr_q;
        bram_we_d    = 1'b0;
        bram_wdata_d = bram_wdata_q;
        rd_issue     = 1'b0;
        rd_sob       = 1'b0;
        rd_oob       = 1'b0;
        unique case (sel)
            GntVga: begin
                bram_addr_d = lin_addr(bus.vga_h, bus.vga_w);
                rd_issue    = 1'b1;
                rd_oob      = vga_oob;
                oob_d       = oob_q | vga_oob;
            end
            GntLd: begin
                bram_addr_d  = ld_addr_q;
                bram_we_d    = 1'b1;
                bram_wdata_d = bus.ld_wdata;
                ld_addr_d    = ld_addr_q + ADDR_W'(1);
                if (ld_addr_q == ADDR_W'(NPIX - 1)) all_loaded_d = 1'b1;
            end
            GntSob: begin
                bram_addr_d = lin_addr(bus.sob_h, bus.sob_w);
                oob_d       = oob_q | sob_oob;
                if (bus.sob_we) begin
                    // Out-of-range writes are granted but never reach the array.
                    bram_we_d    = !sob_oob;
                    bram_wdata_d = bus.sob_wdata;
                end else begin
                    rd_issue = 1'b1;
                    rd_sob   = 1'b1;
                    rd_oob   = sob_oob;
                end
            end
            default: ;
        endcase

        starve_d = starve_q;
        if (!all_loaded_q || !bus.sob_req || sel == GntSob) begin
            starve_d = '0;
        end else if (starve_q != SW'(STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_addr_q    <= '0;
            bram_addr_q  <= '0;
            bram_we_q    <= 1'b0;
            bram_wdata_q <= '0;
            all_loaded_q <= 1'b0;
            oob_q        <= 1'b0;
            starve_q     <= '0;
            tag_vld_q    <= '0;
            tag_sob_q    <= '0;
            tag_oob_q    <= '0;
        end else begin
            ld_addr_q    <= ld_addr_d;
            bram_addr_q  <= bram_addr_d;
            bram_we_q    <= bram_we_d;
            bram_wdata_q <= bram_wdata_d;
            all_loaded_q <= all_loaded_d;
            oob_q        <= oob_d;
            starve_q     <= starve_d;
            // Tag enters stage 0 with the registered address; the last stage lines up with rdata.
            tag_vld_q    <= (tag_vld_q << 1) | TD'(rd_issue);
            tag_sob_q    <= (tag_sob_q << 1) | TD'(rd_sob);
            tag_oob_q    <= (tag_oob_q << 1) | TD'(rd_oob);
        end
    end

    assign bus.vga_gnt    = (sel == GntVga);
    assign bus.ld_gnt     = (sel == GntLd);
    assign bus.sob_gnt    = (sel == GntSob);
    assign bus.vga_rvalid = tag_vld_q[TD-1] && !tag_sob_q[TD-1];
    assign bus.sob_rvalid = tag_vld_q[TD-1] && tag_sob_q[TD-1];
    assign bus.rdata      = (tag_vld_q[TD-1] && !tag_oob_q[TD-1]) ? bus.bram_rdata : 8'h00;
    assign bus.bram_addr  = bram_addr_q;
    assign bus.bram_we    = bram_we_q;
    assign bus.bram_wdata = bram_wdata_q;
    assign bus.all_loaded = all_loaded_q;
    assign bus.oob_err    = oob_q;
endmodule

// File: tb/tb_frame_port_arbiter.sv
// Bench for frame_port_arbiter on a 4x3 frame: directed steps plus randomized traffic,
// checked cycle by cycle against a behavioural priority/memory model and a BRAM stand-in.
module tb_frame_port_arbiter;
    localparam int unsigned W    = 4;
    localparam int unsigned H    = 3;
    localparam int unsigned AW   = 4;
    localparam int unsigned SMAX = 8;

    logic clk;
    logic reset;

    frame_port_arbiter_if #(.ADDR_W(AW)) bus ();

    frame_port_arbiter #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .ADDR_W    (AW),
        .RD_LAT    (1),
        .STARVE_MAX(SMAX)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // BRAM stand-in with one cycle of read latency.
    logic [7:0] mem [16] = '{default: 8'h00};
    always_ff @(posedge clk) begin
        if (bus.bram_we) mem[bus.bram_addr] <= bus.bram_wdata;
        bus.bram_rdata <= mem[bus.bram_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         due;
        bit         sob;
        logic [7:0] data;
    } ret_t;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    ret_t       rq[$];
    logic [7:0] mem_m [16] = '{default: 8'h00};
    bit         m_loaded = 0;
    bit         m_oob    = 0;
    int         m_ld_cnt = 0;
    int         m_starve = 0;
    int         m_addr   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive requests, check grants, then registered outputs and read returns.
    task automatic step(input bit vr, input int vh, input int vw, input bit lr,
                        input logic [7:0] ld, input bit sr, input bit swe, input int sh,
                        input int sw, input logic [7:0] sd, output int g);
        bit         se, le, oob, exp_we;
        int         lin;
        logic [7:0] exp_wd;
        ret_t       r;
        bus.vga_req   = vr;
        bus.vga_h     = 16'(vh);
        bus.vga_w     = 16'(vw);
        bus.ld_req    = lr;
        bus.ld_wdata  = ld;
        bus.sob_req   = sr;
        bus.sob_we    = swe;
        bus.sob_h     = 16'(sh);
        bus.sob_w     = 16'(sw);
        bus.sob_wdata = sd;
        #1;
        se = m_loaded && sr;
        le = lr && !m_loaded;
        if (vr) g = 1;
        else if (se && m_starve == SMAX) g = 3;
        else if (le) g = 2;
        else if (se) g = 3;
        else g = 0;
        chk("vga_gnt", 32'(bus.vga_gnt), 32'(g == 1));
        chk("ld_gnt", 32'(bus.ld_gnt), 32'(g == 2));
        chk("sob_gnt", 32'(bus.sob_gnt), 32'(g == 3));

        exp_we = 0;
        exp_wd = 8'h00;
        if (!m_loaded || !sr || g == 3) m_starve = 0;
        else if (m_starve < SMAX) m_starve++;
        if (g == 1) begin
            oob    = (vh >= H) || (vw >= W);
            lin    = (vh * W + vw) % 16;
            m_addr = lin;
            m_oob  = m_oob | oob;
            rq.push_back('{cyc + 2, 1'b0, oob ? 8'h00 : mem_m[lin]});
        end else if (g == 2) begin
            m_addr        = m_ld_cnt;
            exp_we        = 1;
            exp_wd        = ld;
            mem_m[m_addr] = ld;
            m_ld_cnt++;
            if (m_ld_cnt == W * H) m_loaded = 1;
        end else if (g == 3) begin
            oob    = (sh >= H) || (sw >= W);
            lin    = (sh * W + sw) % 16;
            m_addr = lin;
            m_oob  = m_oob | oob;
            if (swe) begin
                exp_we = !oob;
                exp_wd = sd;
                if (!oob) mem_m[lin] = sd;
            end else begin
                rq.push_back('{cyc + 2, 1'b1, oob ? 8'h00 : mem_m[lin]});
            end
        end

        @(posedge clk);
        #1;
        cyc++;
        chk("bram_we", 32'(bus.bram_we), 32'(exp_we));
        chk("bram_addr", 32'(bus.bram_addr), 32'(m_addr));
        if (exp_we) chk("bram_wdata", 32'(bus.bram_wdata), 32'(exp_wd));
        chk("all_loaded", 32'(bus.all_loaded), 32'(m_loaded));
        chk("oob_err", 32'(bus.oob_err), 32'(m_oob));
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            chk("vga_rvalid", 32'(bus.vga_rvalid), 32'(!r.sob));
            chk("sob_rvalid", 32'(bus.sob_rvalid), 32'(r.sob));
            chk("rdata", 32'(bus.rdata), 32'(r.data));
        end else begin
            chk("vga_rvalid_idle", 32'(bus.vga_rvalid), 32'(0));
            chk("sob_rvalid_idle", 32'(bus.sob_rvalid), 32'(0));
        end
    endtask

    task automatic idle(input int n);
        int g;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, g);
    endtask

    task automatic do_reset();
        bus.vga_req = 0;
        bus.ld_req  = 0;
        bus.sob_req = 0;
        reset = 1'b1;
        #1;
        chk("rst_vga_gnt", 32'(bus.vga_gnt), 32'(0));
        chk("rst_ld_gnt", 32'(bus.ld_gnt), 32'(0));
        chk("rst_sob_gnt", 32'(bus.sob_gnt), 32'(0));
        chk("rst_vga_rvalid", 32'(bus.vga_rvalid), 32'(0));
        chk("rst_sob_rvalid", 32'(bus.sob_rvalid), 32'(0));
        chk("rst_bram_addr", 32'(bus.bram_addr), 32'(0));
        chk("rst_bram_we", 32'(bus.bram_we), 32'(0));
        chk("rst_bram_wdata", 32'(bus.bram_wdata), 32'(0));
        chk("rst_rdata", 32'(bus.rdata), 32'(0));
        chk("rst_all_loaded", 32'(bus.all_loaded), 32'(0));
        chk("rst_oob_err", 32'(bus.oob_err), 32'(0));
        @(posedge clk);
        #1;
        cyc++;
        reset    = 1'b0;
        m_loaded = 0;
        m_oob    = 0;
        m_ld_cnt = 0;
        m_starve = 0;
        m_addr   = 0;
        rq.delete();
    endtask

    initial begin
        int         g;
        bit         pv, pl, ps, swe;
        int         vh, vw, sh, sw;
        logic [7:0] ldv, sd;

        reset         = 1'b1;
        bus.vga_h     = '0;
        bus.vga_w     = '0;
        bus.ld_wdata  = '0;
        bus.sob_we    = 1'b0;
        bus.sob_h     = '0;
        bus.sob_w     = '0;
        bus.sob_wdata = '0;
        do_reset();

        // Load the 4x3 frame with 0x10..0x1B, then one extra request that must be ignored.
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 8'(16 + i), 0, 0, 0, 0, 8'h00, g);
        step(0, 0, 0, 1, 8'h1C, 0, 0, 0, 0, 8'h00, g);

        // VGA read of (1,2): address 6, data 0x16 two cycles after the grant.
        step(1, 1, 2, 0, 8'h00, 0, 0, 0, 0, 8'h00, g);
        idle(2);

        // All three requesting: VGA wins every cycle, Sobel takes over once VGA drops.
        for (int i = 0; i < 10; i++) step(1, 0, 1, 1, 8'h55, 1, 0, 0, 0, 8'h00, g);
        step(0, 0, 0, 1, 8'h55, 1, 0, 0, 0, 8'h00, g);
        idle(2);

        // Sobel write (2,3)=0xAA, read back (0,0), then out-of-range read (3,0).
        step(0, 0, 0, 0, 8'h00, 1, 1, 2, 3, 8'hAA, g);
        step(0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, g);
        step(0, 0, 0, 0, 8'h00, 1, 0, 3, 0, 8'h00, g);
        idle(4);

        // Randomized traffic from reset; each requester holds its request until granted.
        do_reset();
        pv = 0; pl = 0; ps = 0;
        vh = 0; vw = 0; sh = 0; sw = 0; swe = 0; ldv = 0; sd = 0;
        for (int i = 0; i < 300; i++) begin
            if (!pv && $urandom_range(0, 2) == 0) begin
                pv = 1;
                vh = $urandom_range(0, H);
                vw = $urandom_range(0, W);
            end
            if (!pl && $urandom_range(0, 1) == 1) begin
                pl  = 1;
                ldv = 8'($urandom);
            end
            if (!ps && $urandom_range(0, 1) == 1) begin
                ps  = 1;
                swe = 1'($urandom_range(0, 1));
                sh  = $urandom_range(0, H);
                sw  = $urandom_range(0, W);
                sd  = 8'($urandom);
            end
            step(pv, vh, vw, pl, ldv, ps, swe, sh, sw, sd, g);
            if (g == 1) pv = 0;
            if (g == 2) pl = 0;
            if (g == 3) ps = 0;
        end
        idle(3);

        // Reset one cycle after a VGA read grant: the in-flight read must never return.
        step(1, 1, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00, g);
        do_reset();
        idle(4);
        step(0, 0, 0, 1, 8'h77, 0, 0, 0, 0, 8'h00, g);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
